lane_rr_arbiter: RTL



---
 rtl/lane_rr_arbiter_if.sv | 14 +
 rtl/lane_rr_arbiter.sv | 64 ++++++
 2 files changed

// File: rtl/lane_rr_arbiter_if.sv
// lane_rr_arbiter_if: packed lane request bus plus the single registered output stream.
interface lane_rr_arbiter_if #(parameter int BW = 8, parameter int N = 8);
   localparam int SEL = $clog2(N);
   logic [BW*N-1:0] in_a;
   logic [N-1:0]    in_valid;
   logic [N-1:0]    in_ready;
   logic [BW-1:0]   out_a;
   logic            out_valid;
   logic            out_ready;
   logic [SEL-1:0]  out_sel;
   logic            busy;
   modport master (output in_a, in_valid, out_ready, input in_ready, out_a, out_valid, out_sel, busy);
   modport slave (input in_a, in_valid, out_ready, output in_ready, out_a, out_valid, out_sel, busy);
endinterface

// File: rtl/lane_rr_arbiter.sv
// lane_rr_arbiter: round-robin drain of N lanes onto one registered valid/ready stream.
// Optional LANE_RR_ARBITER_CNT_EN adds a 16-bit wrapping lane-transfer counter (xfer_cnt).
module lane_rr_arbiter #(
   parameter int BW = 8,
   parameter int N = 8,
   localparam int SEL = $clog2(N)
) (
   input logic clk,
   input logic rst_n,
   lane_rr_arbiter_if.slave bus
`ifdef LANE_RR_ARBITER_CNT_EN
   ,
   output logic [15:0] xfer_cnt
`endif
);
   typedef enum logic {EMPTY, FULL} state_t;
   state_t         state_q;
   logic [SEL-1:0] last_q, sel_q, grant_d, idx;
   logic [BW-1:0]  a_q;
   logic           found, load_en, xfer;
   // Wrap by explicit compare so non-power-of-two N never visits indices >= N
   always_comb begin
      found = 1'b0;
      grant_d = last_q;
      idx = last_q;
      for (int k = 0; k < N; k++) begin
         idx = (idx == SEL'(N - 1)) ? '0 : idx + 1'b1;
         if (!found && bus.in_valid[idx]) begin
            found = 1'b1;
            grant_d = idx;
         end
      end
   end
   assign load_en = (state_q == EMPTY) || bus.out_ready;
   assign xfer = found && load_en && rst_n;
   assign bus.in_ready = xfer ? N'(1) << grant_d : '0;
   assign bus.out_a = a_q;
   assign bus.out_sel = sel_q;
   assign bus.out_valid = (state_q == FULL);
   assign bus.busy = (state_q == FULL) || (|bus.in_valid);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         a_q <= '0;
         sel_q <= '0;
         last_q <= SEL'(N - 1);
      end else if (xfer) begin
         state_q <= FULL;
         a_q <= bus.in_a[grant_d*BW +: BW];
         sel_q <= grant_d;
         last_q <= grant_d;
      end else if (bus.out_ready) begin
         state_q <= EMPTY;
      end
   end
`ifdef LANE_RR_ARBITER_CNT_EN
   logic [15:0] cnt_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else if (xfer) cnt_q <= cnt_q + 16'd1;
   end
   assign xfer_cnt = cnt_q;
`endif
endmodule
